// File: rtl/psum_accum_ctrl.sv
// psum_accum_ctrl: sequences the 3-input accumulate adder over the input-channel groups of
// one output-channel tile. Stage S1 registers a product triple and issues the partial-sum
// read; stage S2 drives the adder and either writes the partial sum back or emits the
// final biased sum.
module psum_accum_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned GRP_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  // Tile control
  input  logic              start,
  input  logic [GRP_W-1:0]  cfg_groups,
  input  logic [ADDR_W:0]   cfg_pix,
  output logic              busy,
  output logic              done,
  // Product triples
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [31:0]       prod0,
  input  logic [31:0]       prod1,
  input  logic [31:0]       prod2,
  // Accumulate adder
  output logic [31:0]       adder_in1,
  output logic [31:0]       adder_in2,
  output logic [31:0]       adder_in3,
  output logic [31:0]       adder_psum,
  output logic [1:0]        adder_mode,
  input  logic [31:0]       adder_result,
  // Partial-sum SRAM
  output logic              psum_rd_en,
  output logic [ADDR_W-1:0] psum_rd_addr,
  input  logic [31:0]       psum_rd_data,
  output logic              psum_wr_en,
  output logic [ADDR_W-1:0] psum_wr_addr,
  output logic [31:0]       psum_wr_data,
  // Final sums
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data
);

  localparam int unsigned PixW = ADDR_W + 1;

  localparam logic [1:0] ModeProd = 2'd0;  // products only
  localparam logic [1:0] ModePsum = 2'd1;  // products + psum
  localparam logic [1:0] ModeBias = 2'd2;  // products + psum + bias

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [GRP_W-1:0]  grp_num_q, grp_num_d;
  logic [PixW-1:0]   pix_num_q, pix_num_d;
  logic [GRP_W-1:0]  grp_cnt_q, grp_cnt_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;

  // S2 pipeline register
  logic              s2_valid_q;
  logic              s2_first_q;
  logic              s2_last_q;
  logic [ADDR_W-1:0] s2_addr_q;
  logic [31:0]       in1_q, in2_q, in3_q;
  logic [1:0]        mode_q, mode_d;
  logic              fwd_q, fwd_d;
  logic [31:0]       fwd_data_q;

  logic accept;
  logic grp_first;
  logic grp_last;
  logic pix_last;
  logic s2_wr;
  logic s2_out;

  assign prod_ready = (state_q == StRun);
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign accept     = prod_valid && prod_ready;

  assign grp_first = (grp_cnt_q == '0);
  assign grp_last  = (grp_cnt_q == grp_num_q - GRP_W'(1));
  assign pix_last  = ({1'b0, pix_cnt_q} == pix_num_q - PixW'(1));

  // Tile FSM and group/pixel counters: next state.
  always_comb begin
    state_d   = state_q;
    grp_num_d = grp_num_q;
    pix_num_d = pix_num_q;
    grp_cnt_d = grp_cnt_q;
    pix_cnt_d = pix_cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          grp_num_d = cfg_groups;
          pix_num_d = cfg_pix;
          grp_cnt_d = '0;
          pix_cnt_d = '0;
          // An empty tile skips straight to completion without touching the SRAM.
          if (cfg_groups == '0 || cfg_pix == '0) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (accept) begin
          if (pix_last) begin
            pix_cnt_d = '0;
            if (grp_last) begin
              state_d = StDrain;
            end else begin
              grp_cnt_d = grp_cnt_q + GRP_W'(1);
            end
          end else begin
            pix_cnt_d = pix_cnt_q + ADDR_W'(1);
          end
        end
      end
      // Hold until the final triple has left S2.
      StDrain: begin
        if (!s2_valid_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Tile FSM and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      grp_num_q <= '0;
      pix_num_q <= '0;
      grp_cnt_q <= '0;
      pix_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grp_num_q <= grp_num_d;
      pix_num_q <= pix_num_d;
      grp_cnt_q <= grp_cnt_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  // S1: adder mode for the accepted triple and read-after-write forwarding detect.
  always_comb begin
    mode_d = ModePsum;
    if (grp_last) begin
      mode_d = ModeBias;
    end else if (grp_first) begin
      mode_d = ModeProd;
    end
    // The SRAM returns stale data when S2 writes the address S1 is reading (P == 1).
    fwd_d = psum_rd_en && s2_wr && (s2_addr_q == pix_cnt_q);
  end

  // S1 -> S2 pipeline register; mode holds across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_addr_q  <= '0;
      in1_q      <= '0;
      in2_q      <= '0;
      in3_q      <= '0;
      mode_q     <= ModeProd;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      s2_valid_q <= accept;
      if (accept) begin
        s2_first_q <= grp_first;
        s2_last_q  <= grp_last;
        s2_addr_q  <= pix_cnt_q;
        in1_q      <= prod0;
        in2_q      <= prod1;
        in3_q      <= prod2;
        mode_q     <= mode_d;
        fwd_q      <= fwd_d;
        fwd_data_q <= psum_wr_data;
      end
    end
  end

  assign s2_wr  = s2_valid_q && !s2_last_q;
  assign s2_out = s2_valid_q && s2_last_q;

  // S1 read request and S2 adder, write-back and final-sum outputs.
  always_comb begin
    psum_rd_en   = accept && !grp_first;
    psum_rd_addr = psum_rd_en ? pix_cnt_q : '0;

    adder_in1  = in1_q;
    adder_in2  = in2_q;
    adder_in3  = in3_q;
    adder_mode = mode_q;
    adder_psum = '0;
    if (s2_valid_q && !s2_first_q) begin
      adder_psum = fwd_q ? fwd_data_q : psum_rd_data;
    end

    psum_wr_en   = s2_wr;
    psum_wr_addr = s2_wr ? s2_addr_q : '0;
    psum_wr_data = s2_wr ? adder_result : '0;

    out_valid = s2_out;
    out_addr  = s2_out ? s2_addr_q : '0;
    out_data  = s2_out ? adder_result : '0;
  end

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Bench for psum_accum_ctrl: table of whole-tile vectors plus hand-written sequences for
// forwarding, latency and mid-tile reset. The adder and partial-sum SRAM are modelled here.
module tb_psum_accum_ctrl;

  localparam int AW   = 8;
  localparam int GW   = 6;
  localparam int PIXW = AW + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [GW-1:0]   cfg_groups = '0;
  logic [AW:0]     cfg_pix = '0;
  logic            busy, done;
  logic            prod_valid = 1'b0;
  logic            prod_ready;
  logic [31:0]     prod0 = '0, prod1 = '0, prod2 = '0;
  logic [31:0]     adder_in1, adder_in2, adder_in3, adder_psum, adder_result;
  logic [1:0]      adder_mode;
  logic            psum_rd_en, psum_wr_en, out_valid;
  logic [AW-1:0]   psum_rd_addr, psum_wr_addr, out_addr;
  logic [31:0]     psum_rd_data, psum_wr_data, out_data;
  logic [31:0]     bias = '0;
  logic [31:0]     mem [0:255];

  psum_accum_ctrl #(.ADDR_W(AW), .GRP_W(GW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_groups   (cfg_groups),
    .cfg_pix      (cfg_pix),
    .busy         (busy),
    .done         (done),
    .prod_valid   (prod_valid),
    .prod_ready   (prod_ready),
    .prod0        (prod0),
    .prod1        (prod1),
    .prod2        (prod2),
    .adder_in1    (adder_in1),
    .adder_in2    (adder_in2),
    .adder_in3    (adder_in3),
    .adder_psum   (adder_psum),
    .adder_mode   (adder_mode),
    .adder_result (adder_result),
    .psum_rd_en   (psum_rd_en),
    .psum_rd_addr (psum_rd_addr),
    .psum_rd_data (psum_rd_data),
    .psum_wr_en   (psum_wr_en),
    .psum_wr_addr (psum_wr_addr),
    .psum_wr_data (psum_wr_data),
    .out_valid    (out_valid),
    .out_addr     (out_addr),
    .out_data     (out_data)
  );

  always #5 clk = ~clk;

  // Combinational 3-input accumulate adder with bias in mode 2.
  assign adder_result = adder_in1 + adder_in2 + adder_in3 + adder_psum +
                        ((adder_mode == 2'd2) ? bias : 32'd0);

  // Synchronous SRAM: read data one cycle later, old data on same-cycle read/write.
  always @(posedge clk) begin
    if (psum_rd_en) psum_rd_data <= mem[psum_rd_addr];
    if (psum_wr_en) mem[psum_wr_addr] <= psum_wr_data;
  end

  // Event log: 0 = out, 1 = write, 2 = read, 3 = done.
  typedef struct {
    int          kind;
    int          addr;
    logic [31:0] data;
    logic [1:0]  mode;
    logic        wr;
  } ev_t;
  ev_t evq[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid)
        evq.push_back('{kind: 0, addr: int'(out_addr), data: out_data, mode: adder_mode,
                        wr: psum_wr_en});
      if (psum_wr_en)
        evq.push_back('{kind: 1, addr: int'(psum_wr_addr), data: psum_wr_data,
                        mode: adder_mode, wr: 1'b1});
      if (psum_rd_en)
        evq.push_back('{kind: 2, addr: int'(psum_rd_addr), data: 32'd0, mode: 2'd0, wr: 1'b0});
      if (done)
        evq.push_back('{kind: 3, addr: 0, data: 32'd0, mode: 2'd0, wr: 1'b0});
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    int g;
    int p;
    int v;        // all three products of every triple
    int bias;
    bit gap;      // bubble after every triple
    bit poke;     // hold start high (with other cfg) while busy
    int exp_out;
    int n_out;
    int n_wr;
    int n_rd;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_tile(input vec_t t, input int idx);
    int base, k, n_o, n_w, n_r, n_d, gi;
    string tag;
    tag  = $sformatf("v%0d", idx);
    base = evq.size();
    bias = t.bias;
    cfg_groups = GW'(t.g);
    cfg_pix    = PIXW'(t.p);
    start      = 1'b1;
    step();
    start = t.poke;
    if (t.poke) begin
      cfg_groups = GW'(7);
      cfg_pix    = PIXW'(5);
    end
    for (int g = 0; g < t.g; g++) begin
      for (int p = 0; p < t.p; p++) begin
        prod0 = t.v; prod1 = t.v; prod2 = t.v;
        prod_valid = 1'b1;
        k = 0;
        while (!prod_ready && k < 20) begin
          step();
          k++;
        end
        if (!prod_ready) check({tag, "_ready_timeout"}, 32'(prod_ready), 32'd1);
        step();
        if (t.gap) begin
          prod_valid = 1'b0;
          step();
        end
      end
    end
    prod_valid = 1'b0;
    start      = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    repeat (3) step();
    check({tag, "_idle"}, 32'(busy), 32'd0);
    n_o = 0; n_w = 0; n_r = 0; n_d = 0;
    for (int i = base; i < evq.size(); i++) begin
      case (evq[i].kind)
        0: begin
          check({tag, "_out_data"}, evq[i].data, t.exp_out);
          check({tag, "_out_addr"}, evq[i].addr, n_o);
          check({tag, "_out_mode"}, 32'(evq[i].mode), 32'd2);
          check({tag, "_out_nowr"}, 32'(evq[i].wr), 32'd0);
          n_o++;
        end
        1: begin
          gi = n_w / t.p;
          check({tag, "_wr_data"}, evq[i].data, (gi + 1) * 3 * t.v);
          check({tag, "_wr_addr"}, evq[i].addr, n_w % t.p);
          check({tag, "_wr_mode"}, 32'(evq[i].mode), (gi == 0) ? 32'd0 : 32'd1);
          n_w++;
        end
        2: begin
          check({tag, "_rd_addr"}, evq[i].addr, n_r % t.p);
          n_r++;
        end
        default: n_d++;
      endcase
    end
    check({tag, "_n_out"}, n_o, t.n_out);
    check({tag, "_n_wr"}, n_w, t.n_wr);
    check({tag, "_n_rd"}, n_r, t.n_rd);
    check({tag, "_n_done"}, n_d, 1);
  endtask

  vec_t vecs[9];
  vec_t vpost;

  initial begin
    int k;
    //           g   p    v             bias gap poke exp_out        out  wr   rd
    vecs[0] = '{3,  2,   1,            5,   0,  0,   14,            2,   4,   4};
    vecs[1] = '{2,  4,   1,            7,   1,  0,   13,            4,   4,   4};
    vecs[2] = '{1,  3,   -2,           100, 0,  1,   94,            3,   0,   0};
    vecs[3] = '{4,  1,   5,            0,   0,  0,   60,            1,   3,   3};
    vecs[4] = '{2,  256, 2,            -1,  0,  0,   11,            256, 256, 256};
    vecs[5] = '{1,  1,   32'h7FFFFFFF, 1,   0,  0,   32'h7FFFFFFE,  1,   0,   0};
    vecs[6] = '{0,  4,   1,            0,   0,  0,   0,             0,   0,   0};
    vecs[7] = '{3,  0,   1,            0,   0,  0,   0,             0,   0,   0};
    vecs[8] = '{63, 2,   1,            0,   1,  1,   189,           2,   124, 124};
    vpost   = '{2,  2,   3,            0,   0,  0,   18,            2,   2,   2};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(prod_ready), 32'd0);
    check("rst_rd_en", 32'(psum_rd_en), 32'd0);
    check("rst_wr_en", 32'(psum_wr_en), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mode", 32'(adder_mode), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) run_tile(vecs[i], i);

    // G=1, P=2: final sums appear one cycle after each accept, done two cycles after last.
    bias = 10;
    cfg_groups = GW'(1);
    cfg_pix    = PIXW'(2);
    start = 1'b1;
    step();
    start = 1'b0;
    check("A_ready", 32'(prod_ready), 32'd1);
    prod0 = 1; prod1 = 2; prod2 = 3;
    prod_valid = 1'b1;
    step();
    check("A_in1", adder_in1, 32'd1);
    check("A_mode0", 32'(adder_mode), 32'd2);
    check("A_psum0", adder_psum, 32'd0);
    check("A_out_valid0", 32'(out_valid), 32'd1);
    check("A_out_addr0", 32'(out_addr), 32'd0);
    check("A_out_data0", out_data, 32'd16);
    check("A_wr_en0", 32'(psum_wr_en), 32'd0);
    prod0 = 4; prod1 = 5; prod2 = 6;
    step();
    prod_valid = 1'b0;
    check("A_out_valid1", 32'(out_valid), 32'd1);
    check("A_out_addr1", 32'(out_addr), 32'd1);
    check("A_out_data1", out_data, 32'd25);
    step();
    check("A_bubble_out", 32'(out_valid), 32'd0);
    check("A_bubble_mode", 32'(adder_mode), 32'd2);
    check("A_done_early", 32'(done), 32'd0);
    step();
    check("A_done", 32'(done), 32'd1);
    step();
    check("A_done_once", 32'(done), 32'd0);
    check("A_idle", 32'(busy), 32'd0);

    // G=2, P=1 back-to-back: the g1 read collides with the g0 write and must be forwarded.
    bias = 0;
    cfg_groups = GW'(2);
    cfg_pix    = PIXW'(1);
    start = 1'b1;
    step();
    start = 1'b0;
    prod0 = 1; prod1 = 1; prod2 = 1;
    prod_valid = 1'b1;
    step();
    prod0 = 2; prod1 = 2; prod2 = 2;
    check("B_wr_en", 32'(psum_wr_en), 32'd1);
    check("B_wr_data", psum_wr_data, 32'd3);
    check("B_mode0", 32'(adder_mode), 32'd0);
    check("B_rd_en", 32'(psum_rd_en), 32'd1);
    step();
    prod_valid = 1'b0;
    check("B_psum_fwd", adder_psum, 32'd3);
    check("B_mode2", 32'(adder_mode), 32'd2);
    check("B_out_valid", 32'(out_valid), 32'd1);
    check("B_out_data", out_data, 32'd9);
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("B_done", 32'(done), 32'd1);
    repeat (2) step();

    // Reset in the middle of group 1 clears every output at once.
    bias = 0;
    cfg_groups = GW'(3);
    cfg_pix    = PIXW'(4);
    start = 1'b1;
    step();
    start = 1'b0;
    prod0 = 1; prod1 = 1; prod2 = 1;
    prod_valid = 1'b1;
    repeat (6) step();
    check("D_pre_wr_en", 32'(psum_wr_en), 32'd1);
    check("D_pre_rd_en", 32'(psum_rd_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("D_busy", 32'(busy), 32'd0);
    check("D_ready", 32'(prod_ready), 32'd0);
    check("D_rd_en", 32'(psum_rd_en), 32'd0);
    check("D_wr_en", 32'(psum_wr_en), 32'd0);
    check("D_wr_data", psum_wr_data, 32'd0);
    check("D_out_valid", 32'(out_valid), 32'd0);
    check("D_mode", 32'(adder_mode), 32'd0);
    check("D_in1", adder_in1, 32'd0);
    check("D_psum", adder_psum, 32'd0);
    prod_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_tile(vpost, 99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
